// File: rtl/inst_trace_buffer.sv
// Retired-instruction trace buffer: circular capture of (pc, inst) that freezes POST_TRIG beats after a trigger.
// Optional per-class instruction counters are built when TRACE_CLASS_CNT_EN is defined.
module inst_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int CNT_W     = 32,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             SI_ClkIn,
  input  logic             SI_Reset_N,
  input  logic             valid,
  input  logic [31:0]      pc,
  input  logic [31:0]      inst,
  input  logic             inta,
  input  logic             arm,
  input  logic [2:0]       trig_en,
  input  logic [31:0]      trig_pc,
  input  logic [AW-1:0]    rd_idx,
  output logic [31:0]      rd_pc,
  output logic [31:0]      rd_inst,
  output logic [1:0]       state,
  output logic [AW:0]      fill,
  output logic [AW-1:0]    trig_pos,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    POST = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t         r_state;
  logic [AW-1:0]  r_wrPtr;
  logic [AW:0]    r_fill;
  logic [AW-1:0]  r_postCnt;
  logic [31:0]    r_rdPc;
  logic [31:0]    r_rdInst;
  logic [63:0]    r_mem [DEPTH];

  logic           w_capturing;
  logic           w_write;
  logic           w_trigger;
  logic [AW-1:0]  w_rdAddr;
  logic           w_rdInRange;

  assign w_capturing = (r_state == PRE) || (r_state == POST);
  // arm has priority over a coincident beat, so that beat never reaches the buffer
  assign w_write     = valid && !arm && w_capturing;
  assign w_trigger   = (r_state == PRE) && w_write &&
                       ((trig_en[0] && (inst[6:0] == OP_SYSTEM)) ||
                        (trig_en[1] && inta) ||
                        (trig_en[2] && (pc == trig_pc)));

  assign w_rdAddr    = r_wrPtr - r_fill[AW-1:0] + rd_idx;
  assign w_rdInRange = {1'b0, rd_idx} < r_fill;

  always_ff @(posedge SI_ClkIn) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= {pc, inst};
    end
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      r_state   <= IDLE;
      r_wrPtr   <= '0;
      r_fill    <= '0;
      r_postCnt <= '0;
    end else if (arm) begin
      r_state   <= PRE;
      r_wrPtr   <= '0;
      r_fill    <= '0;
      r_postCnt <= '0;
    end else if (w_write) begin
      r_wrPtr <= r_wrPtr + 1'b1;
      if (r_fill != (AW+1)'(DEPTH)) begin
        r_fill <= r_fill + 1'b1;
      end
      if (w_trigger) begin
        if (POST_TRIG == 0) begin
          r_state <= DONE;
        end else begin
          r_state   <= POST;
          r_postCnt <= AW'(POST_TRIG);
        end
      end else if (r_state == POST) begin
        r_postCnt <= r_postCnt - 1'b1;
        if (r_postCnt == AW'(1)) begin
          r_state <= DONE;
        end
      end
    end
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      r_rdPc   <= '0;
      r_rdInst <= '0;
    end else if (w_rdInRange) begin
      r_rdPc   <= r_mem[w_rdAddr][63:32];
      r_rdInst <= r_mem[w_rdAddr][31:0];
    end else begin
      r_rdPc   <= '0;
      r_rdInst <= '0;
    end
  end

  assign rd_pc    = r_rdPc;
  assign rd_inst  = r_rdInst;
  assign state    = r_state;
  assign fill     = r_fill;
  // Trigger sits POST_TRIG entries before the newest one; clamps at 0 if the window is short
  assign trig_pos = (r_fill > (AW+1)'(POST_TRIG)) ?
                    AW'(r_fill - (AW+1)'(POST_TRIG) - 1'b1) : '0;

`ifdef TRACE_CLASS_CNT_EN
  logic [CNT_W-1:0] r_cnt [6];
  logic [5:0]       w_hit;

  always_comb begin
    w_hit = '0;
    case (inst[6:0])
      7'b0110011, 7'b0010011, 7'b0110111: w_hit[0] = 1'b1;
      7'b0000011:                         w_hit[1] = 1'b1;
      7'b0100011:                         w_hit[2] = 1'b1;
      7'b1100011:                         w_hit[3] = 1'b1;
      7'b1101111, 7'b1100111:             w_hit[4] = 1'b1;
      7'b1110011:                         w_hit[5] = 1'b1;
      default:                            w_hit    = '0;
    endcase
  end

  // Counters keep running through DONE; only IDLE and arm stop or clear them
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      for (int k = 0; k < 6; k++) r_cnt[k] <= '0;
    end else if (arm) begin
      for (int k = 0; k < 6; k++) r_cnt[k] <= '0;
    end else if (valid && (r_state != IDLE)) begin
      for (int k = 0; k < 6; k++) begin
        if (w_hit[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    case (cnt_sel)
      3'd0:    cnt_out = r_cnt[0];
      3'd1:    cnt_out = r_cnt[1];
      3'd2:    cnt_out = r_cnt[2];
      3'd3:    cnt_out = r_cnt[3];
      3'd4:    cnt_out = r_cnt[4];
      3'd5:    cnt_out = r_cnt[5];
      default: cnt_out = '0;
    endcase
  end
`else
  logic w_unused_cntSel;
  assign w_unused_cntSel = ^cnt_sel;
  assign cnt_out         = '0;
`endif

endmodule
